// File: rtl/uart_tx_ext.sv
// rtl/uart_tx_ext.sv - UART transmitter with prescale, optional parity and one or two stop bits
// All frame settings are captured at acceptance so inputs may change freely mid-frame.
module uart_tx_ext #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter bit LSB_FIRST      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic                      stop2,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy,
  output logic                      done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                    r_state;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_stop2;
  logic                      r_stop_extra;
  logic [PRESCALE_WIDTH-1:0] r_reload;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [BW-1:0]             r_bit_cnt;
  logic                      r_tx;
  logic                      r_busy;
  logic                      r_done;

  logic [PRESCALE_WIDTH-1:0] w_reload_in;
  logic                      w_bit_end;
  logic                      w_next_bit;
  logic [DATA_WIDTH-1:0]     w_shifted;
  logic                      w_parity;

  // A prescale of zero behaves as one cycle per bit.
  assign w_reload_in = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
  assign w_bit_end   = (r_cnt == '0);
  assign w_next_bit  = LSB_FIRST ? r_shift[0] : r_shift[DATA_WIDTH-1];
  assign w_shifted   = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
  assign w_parity    = (^r_data) ^ r_par_typ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_stop2      <= 1'b0;
      r_stop_extra <= 1'b0;
      r_reload     <= '0;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_bit_end) begin
        r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (data_valid) begin
            r_data    <= p_data;
            r_shift   <= p_data;
            r_par_en  <= par_en;
            r_par_typ <= par_typ;
            r_stop2   <= stop2;
            r_reload  <= w_reload_in;
            r_cnt     <= w_reload_in;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx      <= w_next_bit;
            r_shift   <= w_shifted;
            r_bit_cnt <= BW'(1);
            r_cnt     <= r_reload;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_reload;
            if (r_bit_cnt == BW'(DATA_WIDTH)) begin
              if (r_par_en) begin
                r_tx    <= w_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx         <= 1'b1;
                r_stop_extra <= r_stop2;
                r_state      <= S_STOP;
              end
            end else begin
              r_tx      <= w_next_bit;
              r_shift   <= w_shifted;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx         <= 1'b1;
            r_cnt        <= r_reload;
            r_stop_extra <= r_stop2;
            r_state      <= S_STOP;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (r_stop_extra) begin
              r_stop_extra <= 1'b0;
              r_cnt        <= r_reload;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb/tb_uart_tx_ext.sv - scoreboard bench for uart_tx_ext
// Expected line levels per cycle are queued at stimulus time and popped as the DUT runs.
module tb_uart_tx_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        par_en;
  logic        par_typ;
  logic        stop2;
  logic [15:0] prescale;
  logic        tx_out, busy, done;
  logic        tx_m, busy_m, done_m;

  int n_pass  = 0;
  int n_total = 0;
  bit q[$];

  always #5 clk = ~clk;

  uart_tx_ext #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  uart_tx_ext #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
    .tx_out(tx_m), .busy(busy_m), .done(done_m)
  );

  task automatic push_frame(input logic [7:0] d, input bit pe, input bit pt,
                            input bit s2, input int pres, input bit lsb);
    int p;
    p = (pres == 0) ? 1 : pres;
    repeat (p) q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit b;
      b = lsb ? d[i] : d[7-i];
      repeat (p) q.push_back(b);
    end
    if (pe) begin
      bit par;
      par = (^d) ^ pt;
      repeat (p) q.push_back(par);
    end
    repeat (p * (s2 ? 2 : 1)) q.push_back(1'b1);
  endtask

  // Called at a falling edge; scrambles inputs after acceptance to prove they were latched.
  task automatic start_frame(input logic [7:0] d, input bit pe, input bit pt,
                             input bit s2, input int pres, input bit lsb);
    push_frame(d, pe, pt, s2, pres, lsb);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    stop2      = s2;
    prescale   = 16'(pres);
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    p_data     = ~d;
    par_en     = ~pe;
    par_typ    = ~pt;
    stop2      = ~s2;
    prescale   = 16'(pres + 3);
  endtask

  task automatic check_frame(input string name, input bit msb, input int pulse_at);
    int i;
    logic tx_v, busy_v, done_v;
    i = 0;
    while (q.size() > 0) begin
      bit e;
      e = q.pop_front();
      @(negedge clk);
      tx_v   = msb ? tx_m : tx_out;
      busy_v = msb ? busy_m : busy;
      n_total++;
      if (tx_v !== e) $display("FAIL %s tx cycle %0d: got %b want %b", name, i, tx_v, e);
      else n_pass++;
      n_total++;
      if (busy_v !== 1'b1) $display("FAIL %s busy cycle %0d: got %b want 1", name, i, busy_v);
      else n_pass++;
      if (i == pulse_at) begin
        data_valid = 1'b1;
        p_data     = 8'hFF;
      end else begin
        data_valid = 1'b0;
      end
      i++;
    end
    @(negedge clk);
    tx_v   = msb ? tx_m : tx_out;
    busy_v = msb ? busy_m : busy;
    done_v = msb ? done_m : done;
    n_total++;
    if (done_v !== 1'b1) $display("FAIL %s done pulse: got %b want 1", name, done_v);
    else n_pass++;
    n_total++;
    if (busy_v !== 1'b0) $display("FAIL %s busy at done: got %b want 0", name, busy_v);
    else n_pass++;
    n_total++;
    if (tx_v !== 1'b1) $display("FAIL %s tx at done: got %b want 1", name, tx_v);
    else n_pass++;
  endtask

  task automatic check_idle(input string name, input bit msb);
    logic tx_v, busy_v, done_v;
    @(negedge clk);
    tx_v   = msb ? tx_m : tx_out;
    busy_v = msb ? busy_m : busy;
    done_v = msb ? done_m : done;
    n_total++;
    if (done_v !== 1'b0) $display("FAIL %s idle done: got %b want 0", name, done_v);
    else n_pass++;
    n_total++;
    if (busy_v !== 1'b0) $display("FAIL %s idle busy: got %b want 0", name, busy_v);
    else n_pass++;
    n_total++;
    if (tx_v !== 1'b1) $display("FAIL %s idle tx: got %b want 1", name, tx_v);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset outputs: got tx=%b busy=%b done=%b want 1 0 0", tx_out, busy, done);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset_release", 1'b0);
  endtask

  task automatic test_parity_even();
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    check_frame("even_a5", 1'b0, -1);
    check_idle("even_a5", 1'b0);
  endtask

  task automatic test_parity_odd();
    start_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    check_frame("odd_a5", 1'b0, -1);
    check_idle("odd_a5", 1'b0);
  endtask

  task automatic test_prescale_stop2();
    start_frame(8'h3C, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    check_frame("p4_stop2", 1'b0, -1);
    check_idle("p4_stop2", 1'b0);
  endtask

  task automatic test_ignore_busy();
    start_frame(8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1);
    check_frame("ignore_ff", 1'b0, 3);
    check_idle("ignore_ff_a", 1'b0);
    check_idle("ignore_ff_b", 1'b0);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h5A, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    check_frame("b2b_first", 1'b0, -1);
    start_frame(8'hC3, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    check_frame("b2b_second", 1'b0, -1);
    check_idle("b2b", 1'b0);
  endtask

  task automatic test_reset_midframe();
    start_frame(8'h96, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midframe async reset: got tx=%b busy=%b done=%b want 1 0 0", tx_out, busy, done);
    else n_pass++;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle("after_rst_a", 1'b0);
    check_idle("after_rst_b", 1'b0);
    start_frame(8'h96, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    check_frame("after_rst_frame", 1'b0, -1);
    check_idle("after_rst_frame", 1'b0);
  endtask

  task automatic test_msb_first_p0();
    start_frame(8'h80, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_frame("msb_p0", 1'b1, -1);
    check_idle("msb_p0", 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    stop2      = 1'b0;
    prescale   = '0;
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_prescale_stop2();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_msb_first_p0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
